fifo_uart_tx: RTL and testbench

- Downstream consumer of the 32x8 FIFO: drains bytes through the FIFO read port (rd/empty/data_out) and serializes each byte as an 8N1 UART frame on a single TX line.
- Owns the FIFO read strobe; never reads when FIFO is empty.
- Sits between the FIFO and the chip pad / UART receiver model.

---
 rtl/fifo_uart_tx_if.sv | 10 +
 rtl/fifo_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the 32x8 FIFO and its UART transmitter consumer.
// master = consumer that owns the read strobe, slave = FIFO side.
interface fifo_uart_tx_if;
    logic       fifo_rd;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    modport master (output fifo_rd, input fifo_empty, input fifo_data);
    modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the FIFO read port and serializes each as an 8N1 UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd6,
`endif
        ST_STOP   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef FIFO_UART_TX_PARITY_EN
    function automatic logic even_parity_f(input logic [7:0] data_in);
        return ^data_in;
    endfunction
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             rd_q, rd_d;
    logic             done_q, done_d;
    logic             bit_end_s;

    assign bit_end_s = (cnt_q == CNT_LAST);

    // Next-state, counters and the registered output values derived from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = {CNT_W{1'b0}};
                bit_idx_d = 3'd0;
                if (enable && !fifo.fifo_empty) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = fifo.fifo_data;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d     = {CNT_W{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {CNT_W{1'b0}};
                bit_idx_d = 3'd0;
            end
        endcase

        // Outputs are computed from the next state so the flops line up with the state they describe.
        rd_d   = (state_d == ST_POP);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (cnt_d == CNT_LAST);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity_f(shift_d);
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State and output registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rd_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fifo.fifo_rd = rd_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, scoreboard-fed frame receiver, vector table and corner sequences.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_LEN = NBITS * C;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic tx, busy, done;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .fifo   (bus),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    // FIFO model: registered data_out, updated on the read strobe.
    logic [7:0] mem [32];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         rd_on_empty = 0;
    logic [7:0] data_r = 8'h00;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_data  = data_r;

    always @(posedge clock) begin
        if (bus.fifo_rd && (wr_ptr != rd_ptr)) begin
            data_r <= mem[rd_ptr % 32];
            rd_ptr <= rd_ptr + 1;
        end else if (bus.fifo_rd) begin
            rd_on_empty <= rd_on_empty + 1;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 32] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    // Receiver / monitor state.
    bit         rx_active = 1'b0;
    bit         gap_valid = 1'b0;
    bit         rd_prev = 1'b0;
    int         rx_cyc = 0, idle_run = 0, done_at = -1, shape_err = 0;
    int         frames = 0, rd_count = 0, cyc = 0, rd_cyc = -100;
    int         rd_width_err = 0, stray_done = 0;
    logic [7:0] cur_exp = 8'h00, rx_byte = 8'h00, last_byte = 8'h00;
    logic       rx_par = 1'b0, last_par = 1'b0;
    int         gaps [$];

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                rx_active = 1'b0;
                gap_valid = 1'b0;
                idle_run  = 0;
                rd_prev   = 1'b0;
            end else begin
                if (bus.fifo_rd === 1'b1) begin
                    rd_count++;
                    rd_cyc = cyc;
                    if (rd_prev) rd_width_err++;
                end
                rd_prev = (bus.fifo_rd === 1'b1);
                if (!rx_active) begin
                    if (done !== 1'b0) stray_done++;
                    if (tx === 1'b0) begin
                        rx_active = 1'b1;
                        rx_cyc    = 0;
                        done_at   = -1;
                        shape_err = 0;
                        rx_byte   = 8'h00;
                        rx_par    = 1'b0;
                        if (gap_valid) gaps.push_back(idle_run);
                        check("rd_to_start", cyc - rd_cyc, 2);
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", 1, 0);
                            cur_exp = 8'h00;
                        end else begin
                            cur_exp = exp_q.pop_front();
                        end
                    end else begin
                        idle_run++;
                    end
                end
                if (rx_active) begin
                    int   b;
                    logic e;
                    rx_cyc++;
                    b = (rx_cyc - 1) / C;
                    if (b == 0) e = 1'b0;
                    else if (b <= 8) e = cur_exp[b-1];
                    else if (NBITS == 11 && b == 9) e = ^cur_exp;
                    else e = 1'b1;
                    if (tx !== e || busy !== 1'b1) shape_err++;
                    if ((rx_cyc - 1) % C == C / 2) begin
                        if (b >= 1 && b <= 8) rx_byte[b-1] = tx;
                        if (NBITS == 11 && b == 9) rx_par = tx;
                    end
                    if (done === 1'b1) begin
                        if (done_at < 0) done_at = rx_cyc;
                        else shape_err++;
                    end
                    if (rx_cyc == FRAME_LEN) begin
                        check("frame_shape", shape_err, 0);
                        check("done_pos", done_at, FRAME_LEN);
                        check("rx_byte", rx_byte, cur_exp);
                        last_byte = rx_byte;
                        last_par  = rx_par;
                        frames++;
                        rx_active = 1'b0;
                        idle_run  = 0;
                        gap_valid = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < FRAME_LEN + 40) begin
            @(negedge clock);
            k++;
        end
        check(name, done, 1'b1);
        tick(1);
    endtask

    task automatic wait_rd(input string name);
        int k = 0;
        while (bus.fifo_rd !== 1'b1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check(name, bus.fifo_rd, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, f0, g0, bad;
        vecs[0] = '{data: 8'hA5, par: 1'b0};
        vecs[1] = '{data: 8'h07, par: 1'b1};
        vecs[2] = '{data: 8'h00, par: 1'b0};
        vecs[3] = '{data: 8'hFF, par: 1'b0};
        vecs[4] = '{data: 8'h3C, par: 1'b0};
        vecs[5] = '{data: 8'h80, par: 1'b1};

        tick(3);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rd", bus.fifo_rd, 1'b0);
        reset = 1'b1;
        tick(2);

        // Empty guard.
        enable = 1'b1;
        r0 = rd_count;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus.fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_guard", bad, 0);
        check("empty_rd_count", rd_count - r0, 0);

        // Single-frame vectors.
        for (int i = 0; i < 6; i++) begin
            r0 = rd_count;
            f0 = frames;
            push_byte(vecs[i].data);
            wait_done("vec_done");
            check("vec_rd", rd_count - r0, 1);
            check("vec_frames", frames - f0, 1);
            check("vec_byte", last_byte, vecs[i].data);
`ifdef FIFO_UART_TX_PARITY_EN
            check("vec_parity", last_par, vecs[i].par);
`endif
            tick(5);
        end

        // Back-to-back frames queued before enable.
        enable = 1'b0;
        tick(2);
        r0 = rd_count;
        g0 = gaps.size();
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_done("b2b_done");
        check("b2b_rd", rd_count - r0, 3);
        check("b2b_gap_count", gaps.size() - g0, 3);
        check("b2b_gap1", gaps[g0 + 1], 3);
        check("b2b_gap2", gaps[g0 + 2], 3);
        check("b2b_fifo_empty", bus.fifo_empty, 1'b1);
        check("b2b_last", last_byte, 8'h3C);
        check("b2b_sb_empty", exp_q.size(), 0);

        // Enable drop during DATA bits.
        tick(3);
        r0 = rd_count;
        push_byte(8'h5A);
        wait_rd("drop_rd_seen");
        tick(2 + C + 2 * C);
        check("drop_busy_mid", busy, 1'b1);
        push_byte(8'h11);
        enable = 1'b0;
        wait_done("drop_done");
        check("drop_byte", last_byte, 8'h5A);
        tick(20);
        check("drop_rd_held", rd_count - r0, 1);
        check("drop_idle_busy", busy, 1'b0);
        check("drop_queued", bus.fifo_empty, 1'b0);
        enable = 1'b1;
        wait_done("resume_done");
        check("resume_rd", rd_count - r0, 2);
        check("resume_byte", last_byte, 8'h11);

        // Asynchronous reset mid-frame.
        tick(3);
        push_byte(8'hC3);
        wait_rd("rst_rd_seen");
        tick(15);
        check("pre_reset_tx", tx, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("async_tx", tx, 1'b1);
        check("async_busy", busy, 1'b0);
        check("async_rd", bus.fifo_rd, 1'b0);
        check("async_done", done, 1'b0);
        tick(3);
        reset = 1'b1;
        r0 = rd_count;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post_reset_rd", rd_count - r0, 0);
        check("post_reset_idle", bad, 0);

        check("rd_pulse_width", rd_width_err, 0);
        check("stray_done", stray_done, 0);
        check("rd_on_empty", rd_on_empty, 0);
        check("sb_final_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
